// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings and a clog2 helper.
package usr_pkg;

  typedef enum logic [2:0] {
    USR_HOLD = 3'b000,
    USR_LOAD = 3'b001,
    USR_SHL  = 3'b010,
    USR_SHR  = 3'b011,
    USR_ASR  = 3'b100,
    USR_ROL  = 3'b101,
    USR_ROR  = 3'b110,
    USR_CLR  = 3'b111
  } usr_mode_e;

  localparam int USR_MODE_W = 3;

  function automatic int usr_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/usr_shifter.sv
// Combinational barrel shifter/rotator for the universal shift register, built as one
// mux stage per shift-amount bit.
module usr_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = usr_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [AW-1:0]    AMT,
  input  logic [2:0]       MODE,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] next_q
);

  localparam bit POW2 = (WIDTH == (1 << AW));

  logic [AW-1:0]    amt_mod;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] fill_l;
  logic [WIDTH-1:0] fill_r;
  int unsigned      sh;

  // Non-power-of-two widths can see AMT >= WIDTH; fold it back into range first.
  assign amt_mod = POW2 ? AMT : AW'(32'(AMT) % WIDTH);
  assign fill_l  = {WIDTH{SI_L}};
  assign fill_r  = {WIDTH{SI_R}};

  always_comb begin
    s  = Q;
    sh = 0;
    for (int k = 0; k < AW; k++) begin
      sh = 32'd1 << k;
      if (amt_mod[k]) begin
        case (MODE)
          USR_SHL: s = (s << sh) | (fill_l >> (WIDTH - sh));
          USR_SHR: s = (s >> sh) | (fill_r << (WIDTH - sh));
          USR_ASR: s = $unsigned($signed(s) >>> sh);
          USR_ROL: s = (s << sh) | (s >> (WIDTH - sh));
          USR_ROR: s = (s >> sh) | (s << (WIDTH - sh));
          default: s = s;
        endcase
      end
    end
    next_q = s;
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear with multi-bit amount and serial ends.
// Define PARITY_EN to add the registered parity output PAR.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               AW      = usr_clog2(WIDTH),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [AW-1:0]    AMT,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] Q,
  output logic             SO_L,
  output logic             SO_R,
  output logic             ZERO
`ifdef PARITY_EN
  , output logic           PAR
`endif
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] next_q;

  usr_shifter #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_shifter (
    .Q      (Q),
    .AMT    (AMT),
    .MODE   (MODE),
    .SI_L   (SI_L),
    .SI_R   (SI_R),
    .next_q (shift_q)
  );

  always_comb begin
    next_q = Q;
    if (EN) begin
      case (MODE)
        USR_HOLD: next_q = Q;
        USR_LOAD: next_q = D;
        USR_CLR:  next_q = RST_VAL;
        default:  next_q = shift_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Q <= RST_VAL;
    else     Q <= next_q;
  end

`ifdef PARITY_EN
  // Parity of the value being stored, so PAR always matches ^Q without a read-side XOR tree.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) PAR <= ^RST_VAL;
    else     PAR <= ^next_q;
  end
`endif

  assign SO_L = Q[WIDTH-1];
  assign SO_R = Q[0];
  assign ZERO = (Q == '0);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8, RST_VAL=0): directed vectors plus
// randomized operations against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic [2:0]   MODE = 3'd0;
  logic [2:0]   AMT = 3'd0;
  logic [W-1:0] D = '0;
  logic         SI_L = 1'b0;
  logic         SI_R = 1'b0;
  logic [W-1:0] Q;
  logic         SO_L, SO_R, ZERO;
`ifdef PARITY_EN
  logic         PAR;
`endif

  int errors = 0;
  int checks = 0;
  int mq = 0;

  universal_shift_reg #(.WIDTH(W), .AW(3), .RST_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .AMT(AMT), .D(D),
    .SI_L(SI_L), .SI_R(SI_R), .Q(Q), .SO_L(SO_L), .SO_R(SO_R), .ZERO(ZERO)
`ifdef PARITY_EN
    , .PAR(PAR)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic [7:0] exp_q;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string name, input int exp);
    chk({name, " Q"}, int'(Q), exp);
    chk({name, " SO_L"}, int'(SO_L), (exp >> 7) & 1);
    chk({name, " SO_R"}, int'(SO_R), exp & 1);
    chk({name, " ZERO"}, int'(ZERO), (exp == 0) ? 1 : 0);
`ifdef PARITY_EN
    chk({name, " PAR"}, int'(PAR), int'(^exp[7:0]));
`endif
  endtask

  // Reference: each operation computed with plain integer arithmetic on the whole byte.
  function automatic int model(input int q, input logic en, input logic [2:0] mode,
                               input int amt, input int d, input logic sil, input logic sir);
    int v;
    if (!en) return q;
    case (mode)
      3'd0: v = q;
      3'd1: v = d;
      3'd2: v = (q << amt) | (sil ? ((1 << amt) - 1) : 0);
      3'd3: v = (q >> amt) | (sir ? (255 << (8 - amt)) : 0);
      3'd4: begin
        v = (q >= 128) ? q - 256 : q;
        v = v >>> amt;
      end
      3'd5: v = (q << amt) | (q >> (8 - amt));
      3'd6: v = (q >> amt) | (q << (8 - amt));
      default: v = 0;
    endcase
    return v & 255;
  endfunction

  task automatic drive(input logic en, input logic [2:0] mode, input logic [2:0] amt,
                       input logic [7:0] d, input logic sil, input logic sir);
    EN = en; MODE = mode; AMT = amt; D = d; SI_L = sil; SI_R = sir;
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1'b1, 3'd1, 3'd0, 8'h96, 1'b0, 1'b0, 8'h96},
      '{1'b1, 3'd2, 3'd3, 8'h00, 1'b1, 1'b0, 8'hB7},
      '{1'b1, 3'd1, 3'd0, 8'h90, 1'b0, 1'b0, 8'h90},
      '{1'b1, 3'd4, 3'd2, 8'h00, 1'b0, 1'b1, 8'hE4},
      '{1'b1, 3'd1, 3'd0, 8'h90, 1'b0, 1'b0, 8'h90},
      '{1'b1, 3'd3, 3'd2, 8'h00, 1'b1, 1'b0, 8'h24},
      '{1'b1, 3'd1, 3'd0, 8'h81, 1'b0, 1'b0, 8'h81},
      '{1'b1, 3'd5, 3'd1, 8'h00, 1'b0, 1'b0, 8'h03},
      '{1'b1, 3'd6, 3'd1, 8'h00, 1'b0, 1'b0, 8'h81},
      '{1'b1, 3'd5, 3'd0, 8'h00, 1'b0, 1'b0, 8'h81},
      '{1'b0, 3'd1, 3'd0, 8'hFF, 1'b0, 1'b0, 8'h81},
      '{1'b0, 3'd1, 3'd0, 8'hFF, 1'b0, 1'b0, 8'h81},
      '{1'b0, 3'd1, 3'd0, 8'hFF, 1'b0, 1'b0, 8'h81},
      '{1'b1, 3'd7, 3'd0, 8'hFF, 1'b0, 1'b0, 8'h00},
      '{1'b1, 3'd1, 3'd0, 8'h81, 1'b0, 1'b0, 8'h81},
      '{1'b1, 3'd3, 3'd7, 8'h00, 1'b0, 1'b1, 8'hFF},
      '{1'b1, 3'd2, 3'd7, 8'h00, 1'b0, 1'b0, 8'h80},
      '{1'b1, 3'd0, 3'd5, 8'h3C, 1'b1, 1'b1, 8'h80},
      '{1'b1, 3'd6, 3'd7, 8'h00, 1'b0, 1'b0, 8'h01},
      '{1'b1, 3'd4, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00}
    };

    // Reset state, held across a clock edge with a pending load.
    #2;
    chk_outputs("reset", 0);
    EN = 1'b1; MODE = 3'd1; D = 8'h5A;
    @(posedge CLK); #1;
    chk_outputs("reset held", 0);
    RST = 1'b0;
    drive(1'b1, 3'd1, 3'd0, 8'h5A, 1'b0, 1'b0);
    chk_outputs("first op after reset", 8'h5A);

    // Async reset pulsed between edges clears without a clock.
    drive(1'b1, 3'd1, 3'd0, 8'hA5, 1'b0, 1'b0);
    chk_outputs("load A5", 8'hA5);
    #2 RST = 1'b1;
    #1 chk_outputs("async reset", 0);
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].amt, vecs[i].d, vecs[i].sil, vecs[i].sir);
      chk_outputs($sformatf("vec%0d", i), int'(vecs[i].exp_q));
    end

    // Randomized operations with occasional mid-cycle reset.
    mq = int'(Q);
    for (int n = 0; n < 1000; n++) begin
      logic       en;
      logic [2:0] mode, amt;
      logic [7:0] d;
      logic       sil, sir;
      en   = ($urandom_range(0, 7) != 0);
      mode = 3'($urandom_range(0, 7));
      amt  = 3'($urandom_range(0, 7));
      d    = 8'($urandom_range(0, 255));
      sil  = 1'($urandom_range(0, 1));
      sir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #2 RST = 1'b1;
        #1 mq = 0;
        chk_outputs($sformatf("rand%0d reset", n), mq);
        RST = 1'b0;
      end
      mq = model(mq, en, mode, int'(amt), int'(d), sil, sir);
      drive(en, mode, amt, d, sil, sir);
      chk_outputs($sformatf("rand%0d", n), mq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
